// File: rtl/alu_request_scheduler.sv
// alu_request_scheduler: round-robin sharing of one combinational signed 8-bit arithmetic unit between two requesters
module alu_request_scheduler #(
    parameter int LATENCY = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic [7:0]       au_a,
    output logic [7:0]       au_b,
    output logic [1:0]       au_op,
    input  logic [15:0]      au_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [15:0]      rsp_result,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [3:0] LOAD = 4'(LATENCY - 1);
    state_t state, state_nx;
    logic last_grant, gnt, hs, div0, cnt_zero;
    logic [3:0] cnt;
    logic [7:0] sel_a, sel_b;
    logic [1:0] sel_op;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    // with both requesters valid, the one that did not win last time is granted
    always_comb begin
        gnt = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        hs = (state == IDLE) && (req0_valid || req1_valid);
        sel_a = gnt ? req1_a : req0_a;
        sel_b = gnt ? req1_b : req0_b;
        sel_op = gnt ? req1_op : req0_op;
        div0 = (sel_op == 2'b11) && (sel_b == 8'd0);
        cnt_zero = cnt == 4'd0;
        req0_ready = hs && !gnt;
        req1_ready = hs && gnt;
        rsp_valid = state == RESP;
        busy = state != IDLE;
        state_nx = (state == IDLE && hs) ? (div0 ? RESP : EXEC) :
                   (state == EXEC && cnt_zero) ? RESP :
                   (state == RESP && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            last_grant <= 1'b1;
            cnt <= 4'd0;
            au_a <= 8'd0;
            au_b <= 8'd0;
            au_op <= 2'd0;
            rsp_id <= 1'b0;
            rsp_result <= 16'd0;
            rsp_err <= 1'b0;
            ops_done <= '0;
        end else begin
            if (hs) begin
                last_grant <= gnt;
                rsp_id <= gnt;
                if (div0) begin
                    rsp_result <= 16'd0;
                    rsp_err <= 1'b1;
                end else begin
                    au_a <= sel_a;
                    au_b <= sel_b;
                    au_op <= sel_op;
                    cnt <= LOAD;
                end
            end
            if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (cnt_zero) begin
                    rsp_result <= au_result;
                    rsp_err <= 1'b0;
                end
            end
            if (rsp_valid && rsp_ready) ops_done <= ops_done + CNT_W'(1);
        end
endmodule

// File: tb/tb_alu_request_scheduler.sv
// tb_alu_request_scheduler: directed and random stimulus against a transaction-timing reference model
module tb_alu_request_scheduler;
    localparam int LAT = 2;
    logic clk = 1'b0, rst;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, au_a, au_b;
    logic [1:0] req0_op, req1_op, au_op;
    logic [15:0] au_result, rsp_result, ops_done;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    int checks = 0, errors = 0, cyc = 0;
    logic m_busy, m_lg, m_id, m_err;
    logic [15:0] m_res, m_done;
    logic [7:0] m_a, m_b;
    logic [1:0] m_op;
    int m_rdy;
    logic s_r0, s_r1, s_rv, s_id, s_err;
    logic [15:0] s_res, s_done;
    logic [17:0] s_au;
    logic g[$];

    alu_request_scheduler #(.LATENCY(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_result(au_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic signed [7:0] sa, sb, q, r;
        logic signed [15:0] p;
        sa = a;
        sb = b;
        p = sa * sb;
        q = (b == 8'd0) ? 8'sd0 : sa / sb;
        r = (b == 8'd0) ? 8'sd0 : sa % sb;
        return op == 2'd0 ? {8'd0, a + b} : op == 2'd1 ? {8'd0, a - b} : op == 2'd2 ? p : {q, r};
    endfunction

    always_comb au_result = alu_f(au_a, au_b, au_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_lg = 1; m_done = 0; m_a = 0; m_b = 0; m_op = 0;
        m_id = 0; m_res = 0; m_err = 0; m_rdy = 0;
    endtask

    task automatic cycle(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1,
                         input logic rr);
        logic e_r0, e_r1, e_rv, id, dz;
        logic [7:0] a, b;
        logic [1:0] op;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready = rr;
        #1;
        e_r0 = !m_busy && v0 && (!v1 || m_lg);
        e_r1 = !m_busy && v1 && (!v0 || !m_lg);
        e_rv = m_busy && cyc >= m_rdy;
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("ops_done", 32'(ops_done), 32'(m_done));
        chk("au_inputs", 32'({au_a, au_b, au_op}), 32'({m_a, m_b, m_op}));
        if (e_rv) chk("rsp_fields", 32'({rsp_id, rsp_err, rsp_result}), 32'({m_id, m_err, m_res}));
        s_r0 = req0_ready; s_r1 = req1_ready; s_rv = rsp_valid; s_id = rsp_id; s_err = rsp_err;
        s_res = rsp_result; s_done = ops_done; s_au = {au_a, au_b, au_op};
        if (e_r0 || e_r1) begin
            id = e_r1;
            a = id ? a1 : a0; b = id ? b1 : b0; op = id ? op1 : op0;
            dz = op == 2'd3 && b == 8'd0;
            m_busy = 1; m_lg = id; m_id = id; m_err = dz;
            m_res = dz ? 16'd0 : alu_f(a, b, op);
            m_rdy = cyc + (dz ? 1 : LAT + 1);
            if (!dz) begin m_a = a; m_b = b; m_op = op; end
        end else if (e_rv && rr) begin
            m_busy = 0;
            m_done = m_done + 16'd1;
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rr);
        cycle(0, 8'd0, 8'd0, 2'd0, 0, 8'd0, 8'd0, 2'd0, rr);
    endtask

    initial begin
        logic [15:0] d0;
        logic [17:0] snap;
        rst = 1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outs", 32'({busy, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}), 32'd0);
        chk("reset_regs", 32'({au_a, au_b, au_op}), 32'd0);
        chk("reset_res", 32'({rsp_result, ops_done}), 32'd0);
        rst = 0;
        @(posedge clk);
        #2;
        // single add from requester 0
        cycle(1, 8'd5, 8'd3, 2'd0, 0, 8'd0, 8'd0, 2'd0, 1);
        chk("add_ready", 32'(s_r0), 32'd1);
        idle(1);
        idle(1);
        idle(1);
        chk("add_rsp", 32'({s_rv, s_id, s_err, s_res}), 32'({1'b1, 1'b0, 1'b0, 16'h0008}));
        idle(1);
        chk("add_done", 32'(s_done), 32'd1);
        // divide by zero leaves the unit inputs alone
        cycle(1, 8'd7, 8'd0, 2'd3, 0, 8'd0, 8'd0, 2'd0, 1);
        idle(1);
        chk("dz_rsp", 32'({s_rv, s_err, s_res}), 32'({1'b1, 1'b1, 16'h0000}));
        chk("dz_au", 32'(s_au), 32'({8'd5, 8'd3, 2'd0}));
        idle(1);
        // signed multiply from requester 1
        cycle(0, 8'd0, 8'd0, 2'd0, 1, 8'hFC, 8'd6, 2'd2, 1);
        idle(1);
        idle(1);
        idle(1);
        chk("mul_rsp", 32'({s_rv, s_id, s_res}), 32'({1'b1, 1'b1, 16'hFFE8}));
        idle(1);
        // round robin with both requesters always valid
        for (int i = 0; i < 4 * (LAT + 2); i++) begin
            cycle(1, 8'd20, 8'd3, 2'd3, 1, 8'd10, 8'd12, 2'd1, 1);
            if (s_r0 || s_r1) g.push_back(s_r1);
            if (s_rv) chk("rr_res", 32'(s_res), s_id ? 32'h00FE : 32'h0602);
        end
        chk("rr_count", g.size(), 32'd4);
        for (int i = 0; i < 4 && i < g.size(); i++) chk("rr_grant", 32'(g[i]), 32'(i % 2));
        for (int i = 0; i < LAT + 2; i++) idle(1);
        // backpressure
        cycle(1, 8'd9, 8'd9, 2'd0, 0, 8'd0, 8'd0, 2'd0, 0);
        for (int i = 0; i < LAT; i++) idle(0);
        d0 = m_done;
        snap = {1'b0, 1'b0, 16'h0012};
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'd1, 8'd1, 2'd0, 1, 8'd2, 8'd2, 2'd0, 0);
            chk("bp_stable", 32'({s_rv, s_id, s_err, s_res}), 32'({1'b1, snap}));
            chk("bp_ready", 32'({s_r0, s_r1}), 32'd0);
            chk("bp_done", 32'(s_done), 32'(d0));
        end
        idle(1);
        idle(0);
        chk("bp_done_inc", 32'(s_done), 32'(d0 + 16'd1));
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a0, b0, a1, b1;
            logic [1:0] o0, o1;
            a0 = 8'($urandom); a1 = 8'($urandom);
            b0 = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
            b1 = ($urandom % 4 == 0) ? 8'd0 : 8'($urandom);
            o0 = 2'($urandom); o1 = 2'($urandom);
            cycle(1'($urandom), a0, b0, o0, 1'($urandom), a1, b1, o1, ($urandom % 4) != 0);
        end
        for (int i = 0; i < 20 && m_busy; i++) idle(1);
        chk("drain_busy", 32'(busy), 32'd0);
        // reset in the middle of EXEC
        cycle(0, 8'd0, 8'd0, 2'd0, 1, 8'd4, 8'd4, 2'd0, 1);
        req1_valid = 0;
        #1;
        rst = 1;
        #1;
        chk("rst_ctrl", 32'({busy, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready}), 32'd0);
        chk("rst_au", 32'({au_a, au_b, au_op}), 32'd0);
        chk("rst_res", 32'({rsp_result, ops_done}), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
        @(posedge clk);
        #2;
        cycle(1, 8'd1, 8'd2, 2'd0, 0, 8'd0, 8'd0, 2'd0, 1);
        chk("post_rst_ready", 32'(s_r0), 32'd1);
        for (int i = 0; i < LAT + 1; i++) idle(1);
        chk("post_rst_rsp", 32'({s_rv, s_id, s_res}), 32'({1'b1, 1'b0, 16'h0003}));
        idle(1);
        chk("post_rst_done", 32'(s_done), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_request_scheduler.md
Name: alu_request_scheduler

Overview:
- Shares one combinational signed 8-bit arithmetic unit between two requesters.
- Per request: round-robin arbitration, operand/op latching, drive of the unit's A/B/op inputs for a fixed settle window, result capture, response on a valid/ready channel tagged with the requester ID.
- Divide-by-zero is intercepted before issue.
- Sits between the control unit's instruction sources and the arithmetic unit.

Parameters:
LATENCY, 2, cycles the unit inputs are held before result capture; legal range 1..15
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  scheduler accepts requester 0 this cycle
req0_a  input  8  requester 0 operand A (signed)
req0_b  input  8  requester 0 operand B (signed)
req0_op  input  2  requester 0 op: 00 add, 01 sub, 10 mul, 11 div
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
au_a  output  8  to arithmetic unit A
au_b  output  8  to arithmetic unit B
au_op  output  2  to arithmetic unit op
au_result  input  16  from arithmetic unit result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that owns the response
rsp_result  output  16  captured result
rsp_err  output  1  1 = divide by zero, result forced to 0
busy  output  1  state is not IDLE
ops_done  output  CNT_W  count of completed responses, wraps

Behaviour:
- Reset: asynchronous, active-high, clock is clk; polarity and synchronicity are fixed.
- Reset values: state IDLE; au_a/au_b/au_op, rsp_result, rsp_id, rsp_err, ops_done all 0; rsp_valid 0; busy 0; last_grant 1 (requester 0 wins first).
- Reset mid-operation aborts the in-flight request; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - One valid requester: it is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - reqN_ready is combinational: 1 only for the granted requester while in IDLE. Both readies are 0 in EXEC and RESP.
- IDLE, handshake (valid & ready):
  - Latch a, b, op and the ID; drive them onto au_a/au_b/au_op from the next cycle.
  - Set last_grant to that ID.
  - If op==11 and b==0: go to RESP with rsp_result=0 and rsp_err=1. Arithmetic unit inputs are left unchanged.
  - Otherwise: load cycle counter with LATENCY-1 and go to EXEC.
- EXEC:
  - au_* are held stable.
  - Counter decrements each cycle.
  - When the counter is 0: capture au_result into rsp_result, clear rsp_err, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: increment ops_done (wrapping at 2^CNT_W-1 to 0), return to IDLE.
  - A new grant is possible in the cycle after the return to IDLE.
- Latency:
  - Normal op: handshake at cycle T gives rsp_valid at cycle T+LATENCY+1.
  - Divide-by-zero: rsp_valid at cycle T+1.
- Throughput: at most one operation in flight; best-case back-to-back issue is every LATENCY+2 cycles.
- Width rules: au_result is passed through unmodified. The unit zero-extends add/sub results and packs {quotient, remainder} for div.
- Stability: requesters may change inputs after their handshake without effect. A valid that drops before ready is legal and has no effect.
- rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- Single add: req0 a=5, b=3, op=00, LATENCY=2. Required: req0_ready high in the same cycle; rsp_valid 3 cycles later with rsp_result=0x0008, rsp_id=0, rsp_err=0, ops_done=1.
- Signed multiply: req1 a=-4 (0xFC), b=6, op=10. Required: rsp_result=0xFFE8, rsp_id=1.
- Divide by zero: req0 a=7, b=0, op=11. Required: rsp_valid one cycle after handshake, rsp_result=0, rsp_err=1, au_* unchanged.
- Round-robin fairness: both requesters valid continuously with distinct ops.
  - Grants alternate 0,1,0,1.
  - Responses carry matching IDs and correct results (e.g. req0 20/3 → 0x0602, req1 10−12 → 0x00FE).
- Backpressure: hold rsp_ready=0 for 5 cycles. Required: rsp_* stable, both readies 0, ops_done unchanged; ops_done increments only on the ready cycle.
- Reset mid-EXEC: assert rst during EXEC. Required: immediate return to IDLE, all outputs 0; after release, a new request completes normally with ops_done=1.
